seq_mult_16: RTL
================

# seq_mult_16

Sequential 16×16 unsigned shift-and-add multiplier that sits directly upstream of the `bit_16` ripple adder and drives it. Each cycle it presents one partial-product addition to the adder, then captures the adder's 16-bit sum and carry. After 16 iterations it emits a registered 32-bit product with a start/done handshake. The adder is instantiated beside this block, not inside it: this block owns sequencing, and `bit_16` owns the arithmetic.

## Interface
- No parameters. Width is fixed at 16 to match `bit_16`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a multiply; sampled on `clk` rising edge.
- `multiplicand` input 16: unsigned operand M, captured when `start` is accepted.
- `multiplier` input 16: unsigned operand Q, captured when `start` is accepted.
- `add_a` output 16: to `bit_16.A`; equals the accumulator register.
- `add_b` output 16: to `bit_16.B`; equals M when in RUN and Q[0]=1, else 0.
- `add_cin` output 1: to `bit_16.cin`; constant 0.
- `add_s` input 16: from `bit_16.S`.
- `add_cout` input 1: from `bit_16.cout`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE state.
- `product` output 32: registered result; holds until the next completion or reset.

## Operation
- Internal registers:
  - `m_reg[15:0]`
  - `acc[15:0]` (upper half)
  - `q_reg[15:0]` (lower half / multiplier)
  - `cnt[3:0]`
  - state
- States: IDLE, RUN, DONE.
- IDLE: if `start`=1, load `m_reg`=multiplicand, `q_reg`=multiplier, `acc`=0, `cnt`=0, then go to RUN. Otherwise hold.
- RUN, each cycle:
  - `acc` <= {add_cout, add_s[15:1]}
  - `q_reg` <= {add_s[0], q_reg[15:1]}
  - `cnt` <= cnt+1
  - The effect is {cout,sum,Q} shifted right by one.
- RUN exit: when `cnt`=15, perform the final iteration, load `product` <= {add_cout, add_s, q_reg[15:1]} (the shifted result), and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is also accepted in DONE. In that case it loads the operands as in IDLE and goes to RUN; `done` still pulses that cycle.
- `start` in RUN is ignored. Operands are not re-sampled and the multiply in flight is unaffected.
- Arithmetic:
  - Fully unsigned. The product is exact and never overflows 32 bits.
  - `add_cout` is the 17th bit of each partial sum and must be shifted into `acc[15]`, never dropped.
- Operand 0 (either): runs the full 16 iterations; the result is 0.
- `add_a`, `add_b` and `add_cin` are combinational from registers/state only, never from `add_s`, so there is no combinational loop through the adder.

## Timing
- Reset values:
  - state=IDLE
  - `busy`=0, `done`=0, `product`=0
  - `acc`=0, `q_reg`=0, `m_reg`=0, `cnt`=0
  - hence `add_a`=0, `add_b`=0, `add_cin`=0
- Reset asserted mid-RUN aborts immediately (asynchronously) to the values above. No `done` is issued, and `product` clears to 0.
- Latency:
  - `start` sampled at edge E0.
  - `busy`=1 from E0 until edge E16.
  - `product` is valid and `done`=1 in the cycle following E16, i.e. 17 cycles after the accepting edge.
- Throughput: with `start` held high continuously, one result every 17 cycles.
- The adder path (`acc`/`m_reg` → `bit_16` → `add_s` → `acc`) is single-cycle combinational. Clock period must cover the 16-bit ripple delay.
- `product` changes only at the RUN→DONE edge or on reset.

## Test plan
- Reset then idle: `rst` pulse with no `start` -> `product`=0, `busy`=0, `done`=0, `add_b`=0 throughout.
- Max operands: M=65000, Q=65340 -> `done` 17 cycles after `start`, `product`=4247100000. Intermediate `add_cout`=1 iterations must be exercised.
- Corners:
  - 65535×65535 -> `product`=32'hFFFE0001.
  - 0×58135 -> `product`=0, still 17-cycle latency.
- Mixed values:
  - 58135×3592 -> 208820920.
  - 1005×69 -> 69345.
  - Issued back-to-back with `start` held high -> each `done` 17 cycles apart, and each `product` correct.
- `start` during RUN with new operands (1×1) -> ignored; the original result is delivered unchanged.
- `rst` asserted at iteration 8 of 65000×65340 -> immediate IDLE, no `done`, `product`=0. A subsequent 1005×69 returns 69345.

Source files
------------

// File: rtl/seq_mult_16.sv
// seq_mult_16: 16x16 unsigned shift-and-add multiplier.
// Sequences an external bit_16 adder; 17-cycle start-to-done latency.
module seq_mult_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load;
  logic        last;
  logic [15:0] m_reg;
  logic [15:0] acc;
  logic [15:0] q_reg;
  logic [3:0]  cnt;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; start is honoured in IDLE and DONE only
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == 4'd15) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: {cout,sum,q} shifts right once per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      m_reg <= multiplicand;
      q_reg <= multiplier;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= {add_cout, add_s[15:1]};
      q_reg <= {add_s[0], q_reg[15:1]};
      cnt   <= cnt + 4'd1;
      if (last) product <= {add_cout, add_s, q_reg[15:1]};
    end
  end

  // adder operands come from registers only, so no loop through bit_16
  always_comb begin
    add_a   = acc;
    add_b   = (state == RUN && q_reg[0]) ? m_reg : 16'd0;
    add_cin = 1'b0;
    busy    = (state == RUN);
    done    = (state == DONE);
  end

endmodule
